keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a ROWS x COLS switch matrix by driving one column low at a time,
//   debounces a single pressed key, maps it to a 4-bit key value and queues
//   it in a small FIFO for a downstream consumer.
//
// Ports
//   clk        : clock, all logic on rising edge
//   rst        : synchronous, active-high reset
//   row        : raw row lines, active-low (low = key closed on driven column)
//   col        : column drive, active-low, exactly one bit low
//   out_value  : value of the oldest buffered key (0 when out_valid is low)
//   out_digit  : out_value < BASE (0 when out_valid is low)
//   out_valid  : FIFO not empty
//   out_ready  : consumer takes out_value this cycle
//   overflow   : sticky, a key event was dropped on a full FIFO
//   busy       : FSM is anywhere but SCAN
module keypad_scan_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_TICKS  = 4,
  parameter int BASE       = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [3:0]      out_value,
  output logic            out_digit,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overflow,
  output logic            busy
);

  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DBW  = $clog2(DEB_TICKS + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  // Row-major legend of the standard 4x4 telephone-style pad, entry 0 in the
  // low nibble: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D with * = 14, # = 15.
  localparam logic [63:0] KEYMAP_4X4 = 64'hDF0E_C987_B654_A321;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  // A lone set bit is a valid press; zero or several (ghosting) is not.
  function automatic logic is_onehot(input logic [ROWS-1:0] v);
    return (v != '0) && ((v & (v - ROWS'(1))) == '0);
  endfunction

  function automatic logic [RW-1:0] onehot_index(input logic [ROWS-1:0] v);
    logic [RW-1:0] idx;
    idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (v[i]) idx = RW'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_value(input logic [RW-1:0] r,
                                           input logic [CW-1:0] c);
    int idx;
    idx = int'(r) * COLS + int'(c);
    if (ROWS == 4 && COLS == 4) return KEYMAP_4X4[idx*4 +: 4];
    else                        return idx[3:0];
  endfunction

  logic [ROWS-1:0]   row_p0, row_p1;
  logic [ROWS-1:0]   rp;
  logic [DIVW-1:0]   div_cnt;
  logic              tick;
  state_t            state, state_nxt;
  logic [CW-1:0]     col_idx;
  logic [DBW-1:0]    deb_cnt, rel_cnt;
  logic [ROWS-1:0]   rp_lat;
  logic [RW-1:0]     r_lat;
  logic              col_adv, latch, deb_inc, rel_inc, rel_clr;
  logic [3:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNTW-1:0]   fifo_cnt;
  logic              push, pop, full, wr_en;

  // ---- stage p0/p1: row synchronizer, released lines idle high ----
  always_ff @(posedge clk) begin
    if (rst) begin
      row_p0 <= '1;
      row_p1 <= '1;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  assign rp = ~row_p1;

  // ---- scan tick divider ----
  always_ff @(posedge clk) begin
    if (rst)                                div_cnt <= '0;
    else if (div_cnt == DIVW'(SCAN_DIV - 1)) div_cnt <= '0;
    else                                     div_cnt <= div_cnt + DIVW'(1);
  end

  assign tick = (div_cnt == DIVW'(SCAN_DIV - 1));

  // ---- scan / debounce FSM ----
  always_comb begin
    state_nxt = state;
    col_adv   = 1'b0;
    latch     = 1'b0;
    deb_inc   = 1'b0;
    rel_inc   = 1'b0;
    rel_clr   = 1'b0;
    case (state)
      SCAN: begin
        if (tick) begin
          if (is_onehot(rp)) begin
            latch     = 1'b1;
            state_nxt = DEBOUNCE;
          end else begin
            col_adv = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (rp == rp_lat) begin
            if (deb_cnt == DBW'(DEB_TICKS - 1)) state_nxt = EMIT;
            else                                deb_inc   = 1'b1;
          end else begin
            state_nxt = SCAN;
            col_adv   = 1'b1;
          end
        end
      end
      EMIT: begin
        rel_clr   = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (tick) begin
          if (rp == '0) begin
            if (rel_cnt == DBW'(DEB_TICKS - 1)) begin
              state_nxt = SCAN;
              col_adv   = 1'b1;
            end else begin
              rel_inc = 1'b1;
            end
          end else begin
            rel_clr = 1'b1;
          end
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCAN;
      col_idx <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (col_adv) begin
        if (col_idx == CW'(COLS - 1)) col_idx <= '0;
        else                          col_idx <= col_idx + CW'(1);
      end
      if (latch)        deb_cnt <= '0;
      else if (deb_inc) deb_cnt <= deb_cnt + DBW'(1);
      if (rel_clr)      rel_cnt <= '0;
      else if (rel_inc) rel_cnt <= rel_cnt + DBW'(1);
    end
  end

  // Captured press pattern and its row; only meaningful once latched.
  always_ff @(posedge clk) begin
    if (latch) begin
      rp_lat <= rp;
      r_lat  <= onehot_index(rp);
    end
  end

  assign col  = ~(COLS'(1) << col_idx);
  assign busy = (state != SCAN);

  // ---- key-event FIFO ----
  assign push  = (state == EMIT);
  assign full  = (fifo_cnt == CNTW'(FIFO_DEPTH));
  assign pop   = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNTW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNTW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // column is still held during EMIT, so col_idx is the pressed column
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= key_value(r_lat, col_idx);
  end

  assign out_valid = (fifo_cnt != '0);
  assign out_value = out_valid ? fifo_mem[rd_ptr] : 4'd0;
  assign out_digit = out_valid && (int'(fifo_mem[rd_ptr]) < BASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 switch matrix:
// a closed key pulls its row low whenever its column is driven low.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  out_value;
  logic        out_digit;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        busy;
  logic [15:0] keys;        // bit r*4+c = key at row r, column c closed

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_TICKS(2), .BASE(10), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .out_value(out_value), .out_digit(out_digit), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .busy(busy)
  );

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input string tag, input logic lvl);
    int n = 0;
    while (busy !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, busy, lvl);
  endtask

  task automatic enter_key(input int r, input int c, input string tag);
    keys[r*4+c] = 1'b1;
    wait_busy({tag, "_press"}, 1'b1);
    repeat (12) @(negedge clk);
    keys = '0;
    wait_busy({tag, "_rel"}, 1'b0);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] old_col;
    logic       seen;
    int         n;

    rst = 1'b1; keys = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_col", col, 4'b1110);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_value", out_value, 0);
    check_eq("rst_digit", out_digit, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_busy", busy, 0);

    // Key 8 (row 2, col 1), held for 10 ticks, then released
    keys[2*4+1] = 1'b1;
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_value", out_value, 8);
    check_eq("t1_digit", out_digit, 1);
    check_eq("t1_busy", busy, 1);
    repeat (40) @(negedge clk);
    check_eq("t1_hold_value", out_value, 8);
    pop_one();
    check_eq("t1_single", out_valid, 0);
    check_eq("t1_zero_value", out_value, 0);
    keys = '0;
    repeat (40) @(negedge clk);
    check_eq("t1_after_rel", out_valid, 0);
    check_eq("t1_idle", busy, 0);

    // Key at row 3, col 3 for one tick only
    n = 0;
    while (col == 4'b0111 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (col != 4'b0111 && n < 100) begin @(negedge clk); n++; end
    keys[3*4+3] = 1'b1;
    wait_busy("t2_det", 1'b1);
    keys = '0;
    repeat (30) @(negedge clk);
    check_eq("t2_no_event", out_valid, 0);
    check_eq("t2_idle", busy, 0);
    old_col = col;
    repeat (4) @(negedge clk);
    check_eq("t2_rotate", col, {old_col[2:0], old_col[3]});
    check_eq("t2_onehot", $countones(~col), 1);

    // Ghost: rows 0 and 1 on col 0 together
    keys[0] = 1'b1; keys[4] = 1'b1;
    seen = 1'b0;
    repeat (80) begin @(negedge clk); if (busy) seen = 1'b1; end
    keys = '0;
    check_eq("t3_no_busy", seen, 0);
    check_eq("t3_no_event", out_valid, 0);

    // Keys 1, 2, 3 with consumer stalled
    enter_key(0, 0, "t4_k1");
    enter_key(0, 1, "t4_k2");
    enter_key(0, 2, "t4_k3");
    check_eq("t4_ovf", overflow, 1);
    check_eq("t4_valid", out_valid, 1);
    check_eq("t4_first", out_value, 1);
    check_eq("t4_first_digit", out_digit, 1);
    pop_one();
    check_eq("t4_second", out_value, 2);
    pop_one();
    check_eq("t4_empty", out_valid, 0);
    check_eq("t4_empty_value", out_value, 0);

    // Full FIFO, key 5 emitted in the same clk as a pop
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("t5_ovf_clr", overflow, 0);
    enter_key(0, 0, "t5_k1");
    enter_key(0, 1, "t5_k2");
    keys[1*4+1] = 1'b1;
    wait_busy("t5_press", 1'b1);
    repeat (8) @(negedge clk);   // now in the EMIT cycle
    pop_one();
    check_eq("t5_no_ovf", overflow, 0);
    check_eq("t5_head", out_value, 2);
    keys = '0;
    wait_busy("t5_rel", 1'b0);
    pop_one();
    check_eq("t5_new", out_value, 5);
    check_eq("t5_new_digit", out_digit, 1);
    pop_one();
    check_eq("t5_empty", out_valid, 0);

    // Reset while debouncing (count 1)
    keys[0*4+2] = 1'b1;
    wait_busy("t6_press", 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1; keys = '0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6_col", col, 4'b1110);
    check_eq("t6_valid", out_valid, 0);
    check_eq("t6_busy", busy, 0);
    seen = 1'b0;
    repeat (80) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check_eq("t6_no_event", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
